// File: rtl/csr_timer_pkg.sv
// Shared register map and bit positions for the CSR timer.
package csr_timer_pkg;
  localparam logic [2:0] REG_CONTROL  = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_RELOAD   = 3'd2;
  localparam logic [2:0] REG_COUNTER  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  localparam int EN         = 0;
  localparam int AUTORELOAD = 1;
  localparam int IRQ_EN     = 2;

  localparam int EXPIRED = 0;
endpackage

// File: rtl/csr_if.sv
// CSR bus as seen between the Wishbone-to-CSR bridge and a peripheral.
interface csr_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, csr_we, csr_di, input csr_do);
  modport slave  (input csr_a, csr_we, csr_di, output csr_do);
endinterface

// File: rtl/csr_timer_prescaler.sv
// Free-running divider: counts 0..limit while enabled and ticks on the limit cycle.
module csr_timer_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             tick
);
  logic [WIDTH-1:0] count;

  assign tick = enable && (count == limit);

  // A limit lowered below the running count lets it wrap naturally before matching.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                   count <= '0;
    else if (!enable || clear || tick) count <= '0;
    else                              count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/csr_timer.sv
// 32-bit down-counting CSR timer with prescaler, one-shot/autoreload and level irq.
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter logic [3:0] csr_addr       = 4'h4,
  parameter int         PRESCALE_WIDTH = 16
) (
  input  logic  sys_clk,
  input  logic  sys_rst_n,
  csr_if.slave  bus,
  output logic  irq
);
  logic                      sel, wr, tick, expire;
  logic [2:0]                adr;
  logic [2:0]                control;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [31:0]               reload, counter, rdata;
  logic                      expired;

  assign sel    = (bus.csr_a[13:10] == csr_addr);
  assign adr    = bus.csr_a[2:0];
  assign wr     = sel && bus.csr_we;
  assign expire = tick && (counter == '0);
  assign irq    = expired & control[IRQ_EN];

  csr_timer_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (control[EN]),
    .clear     (wr && (adr == REG_COUNTER)),
    .limit     (prescale),
    .tick      (tick)
  );

  always_comb begin
    rdata = '0;
    case (adr)
      REG_CONTROL:  rdata[2:0] = control;
      REG_PRESCALE: rdata[PRESCALE_WIDTH-1:0] = prescale;
      REG_RELOAD:   rdata = reload;
      REG_COUNTER:  rdata = counter;
      REG_STATUS:   rdata[EXPIRED] = expired;
      default:      rdata = '0;
    endcase
  end

  // Later assignments win: a CONTROL write overrides the one-shot EN drop,
  // a COUNTER write overrides the tick, and expiry overrides a STATUS clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      control    <= '0;
      prescale   <= '0;
      reload     <= '0;
      counter    <= '0;
      expired    <= 1'b0;
      bus.csr_do <= '0;
    end else begin
      if (expire && !control[AUTORELOAD]) control[EN] <= 1'b0;
      if (wr && adr == REG_CONTROL)  control  <= bus.csr_di[2:0];
      if (wr && adr == REG_PRESCALE) prescale <= bus.csr_di[PRESCALE_WIDTH-1:0];
      if (wr && adr == REG_RELOAD)   reload   <= bus.csr_di;

      if (wr && adr == REG_COUNTER) counter <= bus.csr_di;
      else if (tick) begin
        if (counter != '0)           counter <= counter - 32'd1;
        else if (control[AUTORELOAD]) counter <= reload;
      end

      if (expire) expired <= 1'b1;
      else if (wr && adr == REG_STATUS && bus.csr_di[EXPIRED]) expired <= 1'b0;

      bus.csr_do <= sel ? rdata : '0;
    end
  end
endmodule

// File: tb/tb_csr_timer.sv
// Directed + random bench for csr_timer against a cycle-level behavioural model.
module tb_csr_timer;
  import csr_timer_pkg::*;

  localparam int         PW   = 4;
  localparam logic [3:0] PAGE = 4'h4;
  localparam longint     PMOD = longint'(1) << PW;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic irq;

  csr_if bus();

  csr_timer #(.csr_addr(PAGE), .PRESCALE_WIDTH(PW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .irq       (irq)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model state: register values plus the prescaler phase
  bit     m_en, m_ar, m_ie, m_exp;
  longint m_pre, m_rel, m_cnt, m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
    m_pre = 0; m_rel = 0; m_cnt = 0; m_pc = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      REG_CONTROL:  return {29'd0, m_ie, m_ar, m_en};
      REG_PRESCALE: return 32'(m_pre);
      REG_RELOAD:   return 32'(m_rel);
      REG_COUNTER:  return 32'(m_cnt);
      REG_STATUS:   return {31'd0, m_exp};
      default:      return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, advance the model, clock, compare.
  task automatic step(input bit sel, input bit we, input logic [2:0] off, input logic [31:0] d);
    logic [3:0]  pg;
    logic [31:0] exp_do;
    bit          tick, wr, fire, en_n, exp_n;
    longint      pc_n, cnt_n;
    pg = sel ? PAGE : 4'($urandom);
    if (!sel && pg == PAGE) pg = ~PAGE;
    bus.csr_a  = {pg, 7'($urandom), off};
    bus.csr_we = we;
    bus.csr_di = d;

    wr     = sel && we;
    exp_do = sel ? m_read(off) : 32'd0;
    tick   = m_en && (m_pc == m_pre);
    fire   = tick && (m_cnt == 0);
    pc_n   = (!m_en || tick) ? 0 : (m_pc + 1) % PMOD;
    cnt_n  = m_cnt;
    en_n   = m_en;
    exp_n  = m_exp || fire;
    if (tick) begin
      if (m_cnt != 0) cnt_n = m_cnt - 1;
      else if (m_ar)  cnt_n = m_rel;
      else            en_n  = 0;
    end
    if (wr) begin
      case (off)
        REG_CONTROL:  begin en_n = d[EN]; m_ar = d[AUTORELOAD]; m_ie = d[IRQ_EN]; end
        REG_PRESCALE: m_pre = longint'(d) % PMOD;
        REG_RELOAD:   m_rel = longint'(d);
        REG_COUNTER:  begin cnt_n = longint'(d); pc_n = 0; end
        REG_STATUS:   if (d[EXPIRED] && !fire) exp_n = 0;
        default: ;
      endcase
    end
    m_pc = pc_n; m_cnt = cnt_n; m_en = en_n; m_exp = exp_n;

    @(posedge sys_clk);
    #1;
    cyc++;
    check("csr_do", bus.csr_do, exp_do);
    check("irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d); step(1'b1, 1'b1, off, d); endtask
  task automatic rd(input logic [2:0] off); step(1'b1, 1'b0, off, 32'd0); endtask
  task automatic idle(); step(1'b0, 1'($urandom), 3'($urandom), $urandom); endtask

  task automatic wait_set(output int at);
    int n = 0;
    do begin rd(REG_STATUS); n++; end while (!bus.csr_do[EXPIRED] && n < 50);
    at = cyc;
  endtask

  initial begin
    int k, t1, t2, c0, r;
    logic [2:0]  off;
    logic [31:0] d;
    m_reset();
    bus.csr_a = '0; bus.csr_we = 1'b0; bus.csr_di = '0;

    // Reset state
    #12;
    check("rst_do", bus.csr_do, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin rd(3'(i)); check("rst_reg", bus.csr_do, 32'd0); end
    wr(REG_RELOAD, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin idle(); check("unsel_do", bus.csr_do, 32'd0); end
    wr(REG_RELOAD, 32'd0);

    // One-shot: expiry (2+1)*(3+1) cycles after the CONTROL write
    wr(REG_PRESCALE, 3); wr(REG_COUNTER, 2); wr(REG_CONTROL, 3'b101);
    k = 0;
    while (!irq && k < 40) begin idle(); k++; end
    check("oneshot_lat", k, 12);
    rd(REG_CONTROL); check("oneshot_ctrl", bus.csr_do, 32'h4);
    rd(REG_COUNTER); check("oneshot_cnt", bus.csr_do, 32'd0);
    repeat (30) idle();
    rd(REG_COUNTER); check("oneshot_idle", bus.csr_do, 32'd0);
    check("oneshot_irq_hold", {31'd0, irq}, 32'd1);
    wr(REG_STATUS, 1); wr(REG_CONTROL, 0);

    // Autoreload period and clear/re-set
    wr(REG_PRESCALE, 0); wr(REG_RELOAD, 4); wr(REG_COUNTER, 4); wr(REG_CONTROL, 3'b011);
    wait_set(t1);
    wr(REG_STATUS, 1);
    wait_set(t2);
    check("ar_period", t2 - t1, 5);
    check("ar_irq", {31'd0, irq}, 32'd0);

    // STATUS clear landing on the expiry edge (t2+4)
    wr(REG_STATUS, 1);
    idle(); idle();
    wr(REG_STATUS, 1);
    rd(REG_STATUS); check("clr_vs_expiry", bus.csr_do, 32'd1);

    // COUNTER write landing on a tick edge
    wr(REG_CONTROL, 0); wr(REG_STATUS, 1); wr(REG_PRESCALE, 3); wr(REG_COUNTER, 20);
    wr(REG_CONTROL, 3'b001); c0 = cyc;
    repeat (7) idle();
    wr(REG_COUNTER, 7);
    rd(REG_COUNTER); check("cnt_write_wins", bus.csr_do, 32'd7);
    k = 0;
    while (bus.csr_do == 32'd7 && k < 30) begin rd(REG_COUNTER); k++; end
    check("tick_gap", (cyc - 1) - (c0 + 8), 4);
    check("cnt_after_tick", bus.csr_do, 32'd6);

    // Read latency: value at the address-sample cycle
    wr(REG_CONTROL, 0); wr(REG_PRESCALE, 0); wr(REG_COUNTER, 100); wr(REG_CONTROL, 3'b001);
    idle(); idle(); idle();
    rd(REG_COUNTER); check("rd_latency", bus.csr_do, 32'd97);
    rd(REG_COUNTER); check("rd_latency_next", bus.csr_do, 32'd96);

    // Async reset mid-count with irq and csr_do both active
    wr(REG_CONTROL, 0); wr(REG_STATUS, 1); wr(REG_RELOAD, 60); wr(REG_COUNTER, 0);
    wr(REG_CONTROL, 3'b111); c0 = cyc;
    repeat (10) idle();
    rd(REG_COUNTER); check("pre_rst_cnt", bus.csr_do, 32'd51);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_do", bus.csr_do, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    m_reset();
    sys_rst_n = 1'b1;
    repeat (20) idle();
    rd(REG_COUNTER); check("post_rst_cnt", bus.csr_do, 32'd0);
    rd(REG_STATUS);  check("post_rst_status", bus.csr_do, 32'd0);
    rd(REG_CONTROL); check("post_rst_ctrl", bus.csr_do, 32'd0);

    // Random traffic against the model
    repeat (1500) begin
      r   = $urandom_range(0, 9);
      off = 3'($urandom_range(0, 7));
      if (r < 4) idle();
      else if (r < 7) rd(off);
      else begin
        case (off)
          REG_RELOAD:  d = $urandom_range(0, 6);
          REG_COUNTER: d = $urandom_range(0, 12);
          default:     d = $urandom;
        endcase
        wr(off, d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
